// File: rtl/ram_dp_sync.sv
// Synchronous simple-dual-port RAM: byte-enabled write port, pipelined read
// port with valid strobe, and a sequencer that zero-sweeps the array after reset or clr.
module ram_dp_sync #(
  parameter int ADDR_SIZE   = 10,
  parameter int WORD_SIZE   = 32,
  parameter int MEMORY_SIZE = 1024,
  parameter int RD_LATENCY  = 1,
  parameter int RDW_MODE    = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  output logic                   ready,
  input  logic                   wr_cs,
  input  logic [ADDR_SIZE-1:0]   wr_addr,
  input  logic [WORD_SIZE-1:0]   wr_data,
  input  logic [WORD_SIZE/8-1:0] wr_be,
  input  logic                   rd_cs,
  input  logic [ADDR_SIZE-1:0]   rd_addr,
  output logic [WORD_SIZE-1:0]   rd_data,
  output logic                   rd_valid
);

  localparam int unsigned NB = WORD_SIZE / 8;
  localparam int IDX_W = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
  localparam logic [ADDR_SIZE:0] MEM_LIM = (ADDR_SIZE + 1)'(MEMORY_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEMORY_SIZE - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     ptr, ptr_nxt;
  logic [WORD_SIZE-1:0] mem [MEMORY_SIZE];

  logic                 wr_ok, rd_ok, rd_in_range, clr_we;
  logic [IDX_W-1:0]     wr_idx, rd_idx;
  logic                 s1_valid;
  logic [WORD_SIZE-1:0] s1_word, byp_data, rd_word;
  logic [NB-1:0]        byp_be;

  assign wr_idx      = wr_addr[IDX_W-1:0];
  assign rd_idx      = rd_addr[IDX_W-1:0];
  assign rd_in_range = {1'b0, rd_addr} < MEM_LIM;
  assign wr_ok       = rst_n && (state == READY) && wr_cs && ({1'b0, wr_addr} < MEM_LIM);
  assign rd_ok       = (state == READY) && rd_cs;
  assign clr_we      = rst_n && (state == CLEAR);
  assign ready       = (state == READY);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      CLEAR: begin
        if (clr) begin
          ptr_nxt = '0;
        end else if (ptr == LAST_IDX) begin
          state_nxt = READY;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + IDX_W'(1);
        end
      end
      READY: begin
        if (clr) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[ptr] <= '0;
    end else if (wr_ok) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // The array read stays a plain registered read (old data); same-address
  // new-data forwarding is applied afterwards from captured write bytes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLEAR;
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_word  <= '0;
      byp_be   <= '0;
      byp_data <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      s1_valid <= rd_ok;
      if (rd_ok) begin
        s1_word  <= rd_in_range ? mem[rd_idx] : '0;
        byp_be   <= (RDW_MODE != 0 && wr_ok && wr_addr == rd_addr) ? wr_be : '0;
        byp_data <= wr_data;
      end
    end
  end

  always_comb begin
    rd_word = s1_word;
    for (int unsigned i = 0; i < NB; i++) begin
      if (byp_be[i]) rd_word[8*i +: 8] = byp_data[8*i +: 8];
    end
  end

  generate
    if (RD_LATENCY >= 2) begin : g_lat2
      logic [WORD_SIZE-1:0] rd_q;
      logic                 v_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd_q <= '0;
          v_q  <= 1'b0;
        end else begin
          v_q <= s1_valid;
          if (s1_valid) rd_q <= rd_word;
        end
      end
      assign rd_data  = rd_q;
      assign rd_valid = v_q;
    end else begin : g_lat1
      assign rd_data  = rd_word;
      assign rd_valid = s1_valid;
    end
  endgenerate

endmodule
